// File: rtl/tsc_pkg.sv
// Shared types and constants for the turn-signal front end.
package tsc_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TURN_L = 2'd1,
        TURN_R = 2'd2,
        HAZARD = 2'd3
    } tsc_state_e;

    localparam int SYNC_STAGES = 2;
endpackage

// File: rtl/sig_debounce.sv
// Two-flop synchronizer followed by a stability counter; the debounced level
// only follows the synchronized input after DB_CYCLES consecutive disagreeing cycles.
module sig_debounce
    import tsc_pkg::*;
#(
    parameter int DB_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_db
);
    localparam int CW = $clog2(DB_CYCLES);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_db;
    logic                   w_sync;

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign o_db   = r_db;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
            r_cnt  <= '0;
            r_db   <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
            if (w_sync == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DB_CYCLES - 1)) begin
                r_db  <= w_sync;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/turn_signal_ctrl.sv
// Driver-control front end: debounced stalks/button drive a small FSM that
// emits mutually exclusive LEFT/RIGHT/HAZ levels with auto-cancel and lockout.
module turn_signal_ctrl
    import tsc_pkg::*;
#(
    parameter int DB_CYCLES   = 4,
    parameter int AUTO_CANCEL = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic stalk_left_raw,
    input  logic stalk_right_raw,
    input  logic haz_btn_raw,
    input  logic wheel_center_raw,
    output logic LEFT,
    output logic RIGHT,
    output logic HAZ
);
    localparam int TW = $clog2(AUTO_CANCEL);

    logic                   w_left, w_right, w_haz;
    logic [SYNC_STAGES-1:0] r_wheel_sync;
    logic                   r_haz_prev;
    tsc_state_e             r_state, w_next;
    logic [TW-1:0]          r_timer;
    logic                   r_lockout;
    logic                   r_left, r_right, r_haz;
    logic                   w_cancel, w_haz_press, w_wheel, w_in_turn, w_next_turn;

    sig_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_left (
        .i_clk(clk), .i_rst(reset), .i_raw(stalk_left_raw), .o_db(w_left)
    );
    sig_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_right (
        .i_clk(clk), .i_rst(reset), .i_raw(stalk_right_raw), .o_db(w_right)
    );
    sig_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_haz (
        .i_clk(clk), .i_rst(reset), .i_raw(haz_btn_raw), .o_db(w_haz)
    );

    assign w_wheel     = r_wheel_sync[SYNC_STAGES-1];
    assign w_haz_press = w_haz & ~r_haz_prev;
    assign w_in_turn   = (r_state == TURN_L) || (r_state == TURN_R);
    assign w_next_turn = (w_next == TURN_L) || (w_next == TURN_R);

    assign LEFT  = r_left;
    assign RIGHT = r_right;
    assign HAZ   = r_haz;

    always_comb begin
        w_next   = r_state;
        w_cancel = 1'b0;
        if (w_haz_press) begin
            w_next = (r_state == HAZARD) ? IDLE : HAZARD;
        end else if (r_state == HAZARD) begin
            w_next = HAZARD;
        end else if (w_in_turn && (w_wheel || r_timer == TW'(AUTO_CANCEL - 1))) begin
            w_next   = IDLE;
            w_cancel = 1'b1;
        end else if (w_left && w_right) begin
            w_next = IDLE;
        end else if (!r_lockout) begin
            if (w_left)       w_next = TURN_L;
            else if (w_right) w_next = TURN_R;
            else              w_next = IDLE;
        end
    end

    // Outputs are registered decodes of the next state so they align with r_state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_left       <= 1'b0;
            r_right      <= 1'b0;
            r_haz        <= 1'b0;
            r_timer      <= '0;
            r_lockout    <= 1'b0;
            r_haz_prev   <= 1'b0;
            r_wheel_sync <= '0;
        end else begin
            r_state      <= w_next;
            r_left       <= (w_next == TURN_L);
            r_right      <= (w_next == TURN_R);
            r_haz        <= (w_next == HAZARD);
            r_haz_prev   <= w_haz;
            r_wheel_sync <= {r_wheel_sync[SYNC_STAGES-2:0], wheel_center_raw};
            if (w_next_turn && (w_next != r_state))
                r_timer <= '0;
            else if (w_in_turn && (r_timer != '1))
                r_timer <= r_timer + 1'b1;
            if (w_cancel)
                r_lockout <= 1'b1;
            else if (!w_left && !w_right)
                r_lockout <= 1'b0;
        end
    end
endmodule

// File: tb/tb_turn_signal_ctrl.sv
// Directed scenarios plus randomized traffic checked against a behavioural model.
module tb_turn_signal_ctrl;
    localparam int DB   = 4;
    localparam int AC   = 16;
    localparam int TMAX = (1 << $clog2(AC)) - 1;

    logic clk = 1'b0;
    logic rst, sl, sr, hb, wc;
    logic LEFT, RIGHT, HAZ;

    int n_vec = 0;
    int n_err = 0;

    // model: index 0 left, 1 right, 2 hazard, 3 wheel
    int m_s1[4], m_s2[4];
    int m_db[3], m_run[3];
    int m_hp, m_st, m_tmr, m_lock;
    logic [2:0] m_out;

    int rise, high, drop, hz, dn, any_r;
    logic rl, rr, rh;

    always #5 clk = ~clk;

    turn_signal_ctrl #(.DB_CYCLES(DB), .AUTO_CANCEL(AC)) dut (
        .clk(clk), .reset(rst),
        .stalk_left_raw(sl), .stalk_right_raw(sr),
        .haz_btn_raw(hb), .wheel_center_raw(wc),
        .LEFT(LEFT), .RIGHT(RIGHT), .HAZ(HAZ)
    );

    // States: 0 idle, 1 left turn, 2 right turn, 3 hazard.
    task automatic model_step(input logic l, input logic r, input logic h, input logic w, input logic x);
        int raw[4];
        int nx, press, cancel, inturn;
        raw = '{int'(l), int'(r), int'(h), int'(w)};
        if (x) begin
            for (int k = 0; k < 4; k++) begin m_s1[k] = 0; m_s2[k] = 0; end
            for (int k = 0; k < 3; k++) begin m_db[k] = 0; m_run[k] = 0; end
            m_hp = 0; m_st = 0; m_tmr = 0; m_lock = 0; m_out = 3'b000;
            return;
        end
        press  = (m_db[2] == 1 && m_hp == 0) ? 1 : 0;
        inturn = (m_st == 1 || m_st == 2) ? 1 : 0;
        cancel = 0;
        nx     = m_st;
        if (press != 0)                                        nx = (m_st == 3) ? 0 : 3;
        else if (m_st == 3)                                    nx = 3;
        else if (inturn != 0 && (m_s2[3] == 1 || m_tmr == AC-1)) begin nx = 0; cancel = 1; end
        else if (m_db[0] == 1 && m_db[1] == 1)                 nx = 0;
        else if (m_lock == 0)                                  nx = (m_db[0] == 1) ? 1 : ((m_db[1] == 1) ? 2 : 0);
        if ((nx == 1 || nx == 2) && nx != m_st) m_tmr = 0;
        else if (inturn != 0 && m_tmr < TMAX)   m_tmr = m_tmr + 1;
        if (cancel != 0)                        m_lock = 1;
        else if (m_db[0] == 0 && m_db[1] == 0)  m_lock = 0;
        m_hp = m_db[2];
        for (int k = 0; k < 3; k++) begin
            if (m_s2[k] != m_db[k]) begin
                m_run[k] = m_run[k] + 1;
                if (m_run[k] == DB) begin m_db[k] = m_s2[k]; m_run[k] = 0; end
            end else begin
                m_run[k] = 0;
            end
        end
        for (int k = 0; k < 4; k++) begin m_s2[k] = m_s1[k]; m_s1[k] = raw[k]; end
        m_st  = nx;
        m_out = {nx == 1, nx == 2, nx == 3};
    endtask

    task automatic cyc(input logic l, input logic r, input logic h, input logic w, input logic x);
        sl = l; sr = r; hb = h; wc = w; rst = x;
        @(posedge clk);
        model_step(l, r, h, w, x);
        #1;
        n_vec++;
        assert ({LEFT, RIGHT, HAZ} === m_out) else begin
            n_err++;
            $error("FAIL model obs=%b exp=%b t=%0t", {LEFT, RIGHT, HAZ}, m_out, $time);
        end
        n_vec++;
        assert (!(LEFT === 1'b1 && RIGHT === 1'b1)) else begin
            n_err++;
            $error("FAIL excl obs=%b%b exp=not 11 t=%0t", LEFT, RIGHT, $time);
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s obs=%0d exp=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    task automatic wait_left_rise(input string tag);
        rise = 0;
        for (int i = 1; i <= 20; i++) begin
            cyc(1, 0, 0, 0, 0);
            if (LEFT === 1'b1) begin rise = i; break; end
        end
        chk(tag, rise, 7);
    endtask

    initial begin
        sl = 0; sr = 0; hb = 0; wc = 0; rst = 1;

        for (int i = 0; i < 5; i++) begin
            cyc(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1);
            chk("rst_hold", int'({LEFT, RIGHT, HAZ}), 0);
        end
        cyc(0, 0, 0, 0, 0);
        chk("rst_release", int'({LEFT, RIGHT, HAZ}), 0);

        rise = 0; high = 0;
        for (int i = 1; i <= 40; i++) begin
            cyc(1, 0, 0, 0, 0);
            if (LEFT === 1'b1 && rise == 0) rise = i;
            if (LEFT === 1'b1) high++;
        end
        chk("left_latency", rise, 7);
        chk("left_duration", high, 16);
        chk("left_held_off", int'(LEFT), 0);
        idle(10);
        for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0, 0);
        chk("left_repress", int'(LEFT), 1);
        idle(10);

        any_r = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(0, 1'((i % 4) < 2), 0, 0, 0);
            if (RIGHT === 1'b1) any_r = 1;
        end
        chk("right_bounce", any_r, 0);
        rise = 0;
        for (int i = 1; i <= 20; i++) begin
            cyc(0, 1, 0, 0, 0);
            if (RIGHT === 1'b1) begin rise = i; break; end
        end
        chk("right_latency", rise, 7);

        drop = 0;
        for (int i = 1; i <= 6; i++) begin
            cyc(0, 1, 0, 1'(i == 1), 0);
            if (RIGHT === 1'b0 && drop == 0) drop = i;
        end
        chk("wheel_drop", drop, 3);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 1, 0, 0, 0);
            chk("lockout_hold", int'(RIGHT), 0);
        end
        idle(10);
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0, 0);
        chk("right_after_lock", int'(RIGHT), 1);
        idle(10);

        wait_left_rise("left_latency2");
        hz = 0;
        for (int i = 1; i <= 10; i++) begin
            cyc(1, 0, 1, 0, 0);
            if (HAZ === 1'b1 && hz == 0) begin
                hz = i;
                chk("haz_excl_left", int'(LEFT), 0);
            end
        end
        chk("haz_latency", hz, 7);
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0, 0);
        chk("haz_hold", int'(HAZ), 1);
        dn = 0;
        for (int i = 1; i <= 10; i++) begin
            cyc(1, 0, 1, 0, 0);
            if (HAZ === 1'b0) begin
                dn = i;
                chk("haz_off_left", int'(LEFT), 0);
                cyc(1, 0, 1, 0, 0);
                chk("left_resume", int'(LEFT), 1);
                break;
            end
        end
        chk("haz_off_latency", dn, 7);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0);

        for (int i = 0; i < 10; i++) cyc(1, 1, 0, 0, 0);
        chk("both_off", int'({LEFT, RIGHT, HAZ}), 0);
        idle(10);

        wait_left_rise("left_latency3");
        cyc(1, 0, 0, 0, 1);
        chk("rst_mid_turn", int'({LEFT, RIGHT, HAZ}), 0);
        wait_left_rise("left_after_rst");
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1'(i == 0), 0);
        chk("wheel_cancel_left", int'(LEFT), 0);
        cyc(1, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0, 0);
        chk("lock_cleared_by_rst", int'(LEFT), 1);
        idle(10);

        rl = 0; rr = 0; rh = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) rl = ~rl;
            if ($urandom_range(0, 15) == 0) rr = ~rr;
            if ($urandom_range(0, 9) == 0)  rh = ~rh;
            cyc(rl, rr, rh, 1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 499) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
